fp_issue_ctrl: RTL and testbench
================================

// Module: fp_issue_ctrl
// PURPOSE
//  Issue/sequencing stage directly upstream of the FP arithmetic unit.
//  - Accepts FADD/FSUB/FMUL requests from the core and classifies both operands.
//  - Special operands (zero, subnormal, inf, NaN) are resolved locally as a bypass.
//  - Normal operands are sent to the FP unit: this block drives start/multiplicando and waits for finish.
//  - Returns the result, destination tag and exception flags to writeback over a valid/ready handshake.
// PARAMETERS
//  TIMEOUT   128  max cycles in WAIT before abort (8-bit counter, 1..255)
//  TAG_W     5    width of destination register tag
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      request present
//  in_ready    out  1      block can accept a request (high only in IDLE)
//  in_op       in   2      00 FADD, 01 FSUB, 10 FMUL, 11 reserved (treated as FADD)
//  in_a        in   32     operand a, IEEE-754 single
//  in_b        in   32     operand b, IEEE-754 single
//  in_tag      in   TAG_W  destination tag, returned unchanged
//  fpu_a       out  32     operand a to FP unit
//  fpu_b       out  32     operand b to FP unit; for FSUB, in_b with bit 31 inverted
//  fpu_start   out  1      start to FP unit, level
//  fpu_mul     out  1      multiplicando to FP unit
//  fpu_s       in   32     FP unit result
//  fpu_finish  in   1      FP unit done (level, may stay high)
//  res_valid   out  1      result valid
//  res_ready   in   1      writeback accepts the result
//  res_data    out  32     result
//  res_tag     out  TAG_W  tag of the result
//  res_flags   out  3      {NV invalid, TO timeout, BY bypass}
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0 except in_ready=1. Counter 0. Reset mid-operation aborts and loses the request.
//  FSM: IDLE -> CLASSIFY -> (BYPASS | ISSUE) -> WAIT -> DONE -> IDLE
//   IDLE:     on in_valid&in_ready, register op/a/b/tag (sign flip for FSUB applied here) -> CLASSIFY.
//   CLASSIFY: classify both operands -> BYPASS if either is special, else -> ISSUE.
//   BYPASS:   compute special result into res_data, BY=1 -> DONE.
//   ISSUE:    fpu_start=1, fpu_mul=(op==FMUL), clear counter, latch fin_prev=fpu_finish -> WAIT.
//   WAIT:     fpu_start held 1.
//             - Completion is a rising edge of fpu_finish (fpu_finish & ~fin_prev): res_data<=fpu_s -> DONE.
//             - Counter increments each cycle; on reaching TIMEOUT: res_data<=32'h7FC00000, TO=1 -> DONE.
//             - Completion wins over timeout in the same cycle.
//   DONE:     res_valid=1, fpu_start=0. Outputs stable until res_valid&res_ready; that cycle -> IDLE.
//  Classification: a subnormal (exp==0, frac!=0) is flushed to signed zero, because the FP unit assumes a hidden 1.
//  Special rules (NaN checked first; canonical NaN = 32'h7FC00000):
//   - Any NaN -> cNaN; NV=1 if any input NaN is signalling (frac[22]==0).
//   - ADD: +inf + -inf -> cNaN, NV=1. inf + x -> that inf. 0 + x -> x.
//     (+0)+(-0) -> +0. (-0)+(-0) -> -0.
//   - MUL: inf*0 -> cNaN, NV=1. inf*x -> inf with sign a^b. 0*x -> zero with sign a^b.
//  Latency: bypass = 3 cycles from accept to res_valid; FP path = 3 + FP unit latency.
//  in_ready=0 outside IDLE. No pipelining: one request in flight at a time.
// STRUCTURE
//  Shared package fp_pkg:
//   - opcode localparams OP_FADD/OP_FSUB/OP_FMUL
//   - class encoding CL_ZERO/CL_NORM/CL_INF/CL_QNAN/CL_SNAN (3 bits)
//   - CANON_NAN, state encoding
//  Sub-module fp_classify: combinational, 32-bit in -> 3-bit class, instantiated twice.
//  FSM, counter and bypass logic in this module; single always block for the state register with async rst.
// TESTING
//  1 FADD a=3F800000 b=40000000 -> fpu_start rises, fpu_mul=0; model returns 40400000 after 30 cycles -> res 40400000, flags 000.
//  2 FSUB a=40400000 b=3F800000 -> fpu_b=BF800000; FMUL same operands -> fpu_mul=1.
//  3 Bypass: FMUL 7F800000*00000000 -> res 7FC00000, NV=1, BY=1, fpu_start never high.
//    FADD 80000000+80000000 -> 80000000, BY=1.
//  4 sNaN 7F800001 + 3F800000 -> 7FC00000, NV=1. Subnormal 00000001*40000000 -> 00000000, BY=1.
//  5 FP unit never finishes, with fpu_finish held high from a prior op -> after 128 WAIT cycles res 7FC00000, TO=1, no false completion.
//  6 res_ready low 10 cycles -> res_* stable, in_ready=0.
//    rst asserted during WAIT -> immediate IDLE, all outputs 0, in_ready=1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the FP issue stage: opcodes, operand classes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;

  // Opcodes as seen on in_op; 2'b11 is reserved and folded into FADD at accept
  localparam logic [1:0] OP_FADD = 2'b00;
  localparam logic [1:0] OP_FSUB = 2'b01;
  localparam logic [1:0] OP_FMUL = 2'b10;

  // Operand classes; subnormals are reported as CL_ZERO (flush-to-zero)
  localparam logic [2:0] CL_ZERO = 3'd0;
  localparam logic [2:0] CL_NORM = 3'd1;
  localparam logic [2:0] CL_INF  = 3'd2;
  localparam logic [2:0] CL_QNAN = 3'd3;
  localparam logic [2:0] CL_SNAN = 3'd4;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // Issue FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLASSIFY = 3'd1;
  localparam logic [2:0] ST_BYPASS   = 3'd2;
  localparam logic [2:0] ST_ISSUE    = 3'd3;
  localparam logic [2:0] ST_WAIT     = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  function automatic logic cl_is_nan(input logic [2:0] cl);
    return (cl == CL_QNAN) || (cl == CL_SNAN);
  endfunction

endpackage

// File: rtl/fp_issue_ctrl_if.sv
// Bundle of request, FP-unit and result signals around the FP issue stage.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on requests, res_valid/res_ready on results.
interface fp_issue_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic             fpu_start;
  logic             fpu_mul;
  logic [31:0]      fpu_s;
  logic             fpu_finish;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic [2:0]       res_flags;

  // Environment side: core request, FP unit response, writeback ready
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, fpu_s, fpu_finish, res_ready,
    input  in_ready, fpu_a, fpu_b, fpu_start, fpu_mul, res_valid, res_data, res_tag, res_flags
  );

  // Issue stage side
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, fpu_s, fpu_finish, res_ready,
    output in_ready, fpu_a, fpu_b, fpu_start, fpu_mul, res_valid, res_data, res_tag, res_flags
  );
endinterface

// File: rtl/fp_classify.sv
// Classifies the magnitude bits of an IEEE-754 single into zero/normal/inf/qNaN/sNaN.
// Latency: combinational.
// Backpressure: none.
module fp_classify
  import fp_pkg::*;
(
  input  logic [30:0] mag_i,
  output logic [2:0]  cls_o
);
  // Exponent all-ones selects inf/NaN, all-zeros is zero or a flushed subnormal
  always_comb begin
    cls_o = CL_NORM;
    if (mag_i[30:23] == 8'hFF) begin
      if (mag_i[22:0] == 23'd0) cls_o = CL_INF;
      else if (mag_i[22])       cls_o = CL_QNAN;
      else                      cls_o = CL_SNAN;
    end else if (mag_i[30:23] == 8'h00) begin
      cls_o = CL_ZERO;
    end
  end
endmodule

// File: rtl/fp_issue_ctrl.sv
// Issue stage ahead of the FP unit; special operands resolved locally, normals issued.
// Latency: 3 cycles accept->res_valid on bypass, 3 + FP unit latency on the FP path.
// Backpressure: single request in flight; in_ready only in IDLE; result held until res_ready.
module fp_issue_ctrl
  import fp_pkg::*;
#(
  parameter int TIMEOUT = 128,
  parameter int TAG_W   = 5
) (
  input  logic           clk,
  input  logic           rst,
  fp_issue_ctrl_if.slave bus
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      res_q, res_d;
  logic [2:0]       flags_q, flags_d;   // {NV, TO, BY}
  logic [7:0]       cnt_q, cnt_d;
  logic             fin_prev_q, fin_prev_d;

  logic [2:0]       cls_a, cls_b;
  logic             special;
  logic             is_mul;
  logic [31:0]      byp_data;
  logic             byp_nv;
  logic [7:0]       cnt_inc;

  fp_classify u_cls_a (.mag_i(a_q[30:0]), .cls_o(cls_a));
  fp_classify u_cls_b (.mag_i(b_q[30:0]), .cls_o(cls_b));

  assign special = (cls_a != CL_NORM) || (cls_b != CL_NORM);
  assign is_mul  = (op_q == OP_FMUL);
  assign cnt_inc = cnt_q + 8'd1;

  // Special-operand result; b already carries the FSUB sign flip, so ADD rules cover SUB
  always_comb begin
    byp_data = CANON_NAN;
    byp_nv   = 1'b0;
    if (cl_is_nan(cls_a) || cl_is_nan(cls_b)) begin
      byp_nv = (cls_a == CL_SNAN) || (cls_b == CL_SNAN);
    end else if (is_mul) begin
      if ((cls_a == CL_INF && cls_b == CL_ZERO) || (cls_a == CL_ZERO && cls_b == CL_INF))
        byp_nv = 1'b1;
      else if (cls_a == CL_INF || cls_b == CL_INF)
        byp_data = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
      else
        byp_data = {a_q[31] ^ b_q[31], 31'd0};
    end else begin
      if (cls_a == CL_INF && cls_b == CL_INF && a_q[31] != b_q[31])
        byp_nv = 1'b1;
      else if (cls_a == CL_INF)
        byp_data = a_q;
      else if (cls_b == CL_INF)
        byp_data = b_q;
      else if (cls_a == CL_ZERO && cls_b == CL_ZERO)
        byp_data = {a_q[31] & b_q[31], 31'd0};   // -0 only when both are -0
      else if (cls_a == CL_ZERO)
        byp_data = b_q;
      else
        byp_data = a_q;
    end
  end

  // Next-state and datapath updates for the issue sequence
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    res_d      = res_q;
    flags_d    = flags_q;
    cnt_d      = cnt_q;
    fin_prev_d = fin_prev_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d    = (bus.in_op == OP_FMUL) ? OP_FMUL :
                    (bus.in_op == OP_FSUB) ? OP_FSUB : OP_FADD;
          a_d     = bus.in_a;
          b_d     = (bus.in_op == OP_FSUB) ? {~bus.in_b[31], bus.in_b[30:0]} : bus.in_b;
          tag_d   = bus.in_tag;
          flags_d = 3'b000;
          state_d = ST_CLASSIFY;
        end
      end
      ST_CLASSIFY: state_d = special ? ST_BYPASS : ST_ISSUE;
      ST_BYPASS: begin
        res_d   = byp_data;
        flags_d = {byp_nv, 1'b0, 1'b1};
        state_d = ST_DONE;
      end
      ST_ISSUE: begin
        cnt_d      = 8'd0;
        fin_prev_d = bus.fpu_finish;   // a finish level left over from a prior op is not completion
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d      = cnt_inc;
        fin_prev_d = bus.fpu_finish;
        if (bus.fpu_finish && !fin_prev_q) begin
          res_d   = bus.fpu_s;
          state_d = ST_DONE;
        end else if (cnt_inc == TIMEOUT_C) begin
          res_d      = CANON_NAN;
          flags_d[1] = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: if (bus.res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops any request in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Operand, result and timeout registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_FADD;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      cnt_q      <= '0;
      fin_prev_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tag_q      <= tag_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      cnt_q      <= cnt_d;
      fin_prev_q <= fin_prev_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.fpu_start = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign bus.fpu_mul   = bus.fpu_start && is_mul;
  assign bus.fpu_a     = a_q;
  assign bus.fpu_b     = b_q;
  assign bus.res_valid = (state_q == ST_DONE);
  assign bus.res_data  = res_q;
  assign bus.res_tag   = tag_q;
  assign bus.res_flags = flags_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Self-checking bench for fp_issue_ctrl with a behavioural FP unit and a rule-level reference.
// Latency: n/a.
// Backpressure: exercises res_ready stalls and the single-request-in-flight rule.
module tb_fp_issue_ctrl;
  import fp_pkg::*;

  localparam int          TAG_W = 5;
  localparam logic [31:0] CNAN  = 32'h7FC0_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // FP unit behaviour: 0 = finish after fpu_lat cycles, 1 = finish stuck high, 2 = never finish
  int          fpu_mode = 0;
  int          fpu_lat  = 4;
  bit          fpu_ovr_en = 0;
  logic [31:0] fpu_ovr = '0;

  fp_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  fp_issue_ctrl #(.TIMEOUT(128), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Deterministic stand-in for the FP unit's arithmetic, sensitive to every operand bit and the mul select
  function automatic logic [31:0] fpu_hash(input logic [31:0] a, input logic [31:0] b, input logic mul);
    logic [31:0] h;
    h = {a[15:0] ^ b[31:16], b[15:0] + a[31:16]};
    return mul ? (h ^ 32'hA5A5_5A5A) : h;
  endfunction

  initial begin : fpu_model
    bit busy;
    int cnt;
    busy = 0;
    cnt  = 0;
    bus.fpu_finish = 1'b0;
    bus.fpu_s      = '0;
    forever begin
      @(posedge clk); #2;
      if (fpu_mode == 1) begin
        bus.fpu_finish = 1'b1;
        busy = 0;
      end else if (fpu_mode == 2 || !bus.fpu_start) begin
        bus.fpu_finish = 1'b0;
        busy = 0;
      end else begin
        if (!busy) begin busy = 1; cnt = 0; end
        else cnt++;
        if (cnt == fpu_lat) begin
          bus.fpu_finish = 1'b1;
          bus.fpu_s = fpu_ovr_en ? fpu_ovr : fpu_hash(bus.fpu_a, bus.fpu_b, bus.fpu_mul);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit nan_f(input logic [31:0] x);  return x[30:23] == 8'hFF && x[22:0] != 0; endfunction
  function automatic bit snan_f(input logic [31:0] x); return nan_f(x) && !x[22]; endfunction
  function automatic bit inf_f(input logic [31:0] x);  return x[30:23] == 8'hFF && x[22:0] == 0; endfunction
  function automatic bit zero_f(input logic [31:0] x); return x[30:23] == 8'h00; endfunction

  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b_in,
                                    output bit issued, output logic [31:0] d, output logic [2:0] f,
                                    output logic [31:0] b);
    bit mul;
    bit sx;
    b      = (op == 2'b01) ? (b_in ^ 32'h8000_0000) : b_in;   // subtraction adds the negated operand
    mul    = (op == 2'b10);
    sx     = a[31] ^ b[31];
    issued = 0;
    d      = CNAN;
    f      = 3'b001;
    if (nan_f(a) || nan_f(b)) begin
      f[2] = snan_f(a) | snan_f(b);
    end else if (mul) begin
      if ((inf_f(a) && zero_f(b)) || (zero_f(a) && inf_f(b))) f = 3'b101;
      else if (inf_f(a) || inf_f(b))   d = {sx, 8'hFF, 23'd0};
      else if (zero_f(a) || zero_f(b)) d = {sx, 31'd0};
      else issued = 1;
    end else begin
      if (inf_f(a) && inf_f(b) && a[31] != b[31]) f = 3'b101;
      else if (inf_f(a)) d = a;
      else if (inf_f(b)) d = b;
      else if (zero_f(a) && zero_f(b)) d = {a[31] & b[31], 31'd0};
      else if (zero_f(a)) d = b;
      else if (zero_f(b)) d = a;
      else issued = 1;
    end
    if (issued) begin
      f = 3'b000;
      d = fpu_hash(a, b, mul);
    end
  endfunction

  function automatic logic [31:0] rand_operand();
    int   k;
    logic s;
    k = $urandom_range(0, 9);
    s = 1'($urandom_range(0, 1));
    case (k)
      5:       return {s, 31'd0};
      6:       return {s, 8'h00, 23'($urandom_range(1, 23'h7FFFFF))};
      7:       return {s, 8'hFF, 23'd0};
      8:       return {s, 8'hFF, 1'b1, 22'($urandom)};
      9:       return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 22'h3FFFFF))};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // ---------------- transaction driver (observes, does not judge) ----------------
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input int stall,
                        output logic [31:0] d, output logic [2:0] f, output logic [TAG_W-1:0] t,
                        output int lat, output int starts, output logic [31:0] fb, output logic fm,
                        output int unstable, output int rdy_hi, output bit ok);
    int n;
    ok = 0; lat = 0; starts = 0; fb = '0; fm = 1'b0; unstable = 0; rdy_hi = 0;
    d = '0; f = '0; t = '0;
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.res_valid && n < 2000) begin
      if (bus.fpu_start) begin starts++; fb = bus.fpu_b; fm = bus.fpu_mul; end
      @(posedge clk); #1;
      n++;
    end
    if (bus.res_valid) begin
      ok = 1; lat = n;
      d = bus.res_data; f = bus.res_flags; t = bus.res_tag;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        if (bus.res_valid !== 1'b1 || bus.res_data !== d || bus.res_flags !== f || bus.res_tag !== t) unstable++;
        if (bus.in_ready !== 1'b0) rdy_hi++;
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_during: got %b want 1", bus.in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if ({bus.res_valid, bus.fpu_start, bus.fpu_mul} !== 3'b000) begin n_fail++; $display("FAIL rst_ctl: got %b want 000", {bus.res_valid, bus.fpu_start, bus.fpu_mul}); end
    n_checks++; if ({bus.res_data, bus.res_flags, bus.res_tag} !== '0) begin n_fail++; $display("FAIL rst_res: got %h/%b/%h want 0", bus.res_data, bus.res_flags, bus.res_tag); end
    n_checks++; if ({bus.fpu_a, bus.fpu_b} !== 64'd0) begin n_fail++; $display("FAIL rst_fpu_ops: got %h/%h want 0", bus.fpu_a, bus.fpu_b); end
  endtask

  task automatic test_fadd();
    logic [31:0] d, fb; logic [2:0] f; logic [TAG_W-1:0] t; logic fm; int lat, st, un, rh; bit ok;
    fpu_lat = 30; fpu_ovr_en = 1; fpu_ovr = 32'h4040_0000;
    run_op(OP_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd7, 0, d, f, t, lat, st, fb, fm, un, rh, ok);
    fpu_ovr_en = 0;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fadd_done: got %b want 1", ok); end
    n_checks++; if (d !== 32'h4040_0000) begin n_fail++; $display("FAIL fadd_data: got %h want 40400000", d); end
    n_checks++; if (f !== 3'b000) begin n_fail++; $display("FAIL fadd_flags: got %b want 000", f); end
    n_checks++; if (t !== 5'd7) begin n_fail++; $display("FAIL fadd_tag: got %0d want 7", t); end
    n_checks++; if (fm !== 1'b0) begin n_fail++; $display("FAIL fadd_mul: got %b want 0", fm); end
    n_checks++; if (st !== 31) begin n_fail++; $display("FAIL fadd_start_cycles: got %0d want 31", st); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL fadd_latency: got %0d want 33", lat); end
  endtask

  task automatic test_fsub_fmul();
    logic [31:0] d, fb; logic [2:0] f; logic [TAG_W-1:0] t; logic fm; int lat, st, un, rh; bit ok;
    fpu_lat = 5;
    run_op(OP_FSUB, 32'h4040_0000, 32'h3F80_0000, 5'd3, 0, d, f, t, lat, st, fb, fm, un, rh, ok);
    n_checks++; if (fb !== 32'hBF80_0000) begin n_fail++; $display("FAIL fsub_fpu_b: got %h want BF800000", fb); end
    n_checks++; if (fm !== 1'b0) begin n_fail++; $display("FAIL fsub_mul: got %b want 0", fm); end
    n_checks++; if (d !== fpu_hash(32'h4040_0000, 32'hBF80_0000, 1'b0)) begin n_fail++; $display("FAIL fsub_data: got %h want %h", d, fpu_hash(32'h4040_0000, 32'hBF80_0000, 1'b0)); end
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL fsub_latency: got %0d want 8", lat); end
    run_op(OP_FMUL, 32'h4040_0000, 32'h3F80_0000, 5'd4, 0, d, f, t, lat, st, fb, fm, un, rh, ok);
    n_checks++; if (fm !== 1'b1) begin n_fail++; $display("FAIL fmul_mul: got %b want 1", fm); end
    n_checks++; if (fb !== 32'h3F80_0000) begin n_fail++; $display("FAIL fmul_fpu_b: got %h want 3F800000", fb); end
    n_checks++; if (d !== fpu_hash(32'h4040_0000, 32'h3F80_0000, 1'b1)) begin n_fail++; $display("FAIL fmul_data: got %h want %h", d, fpu_hash(32'h4040_0000, 32'h3F80_0000, 1'b1)); end
  endtask

  task automatic test_bypass();
    logic [1:0]  ops [4] = '{OP_FMUL, OP_FADD, OP_FADD, OP_FMUL};
    logic [31:0] as  [4] = '{32'h7F80_0000, 32'h8000_0000, 32'h7F80_0001, 32'h0000_0001};
    logic [31:0] bs  [4] = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h4000_0000};
    logic [31:0] eds [4] = '{32'h7FC0_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h0000_0000};
    logic [2:0]  efs [4] = '{3'b101, 3'b001, 3'b101, 3'b001};
    logic [31:0] d, fb; logic [2:0] f; logic [TAG_W-1:0] t; logic fm; int lat, st, un, rh; bit ok;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], 5'(i + 10), 0, d, f, t, lat, st, fb, fm, un, rh, ok);
      n_checks++; if (d !== eds[i]) begin n_fail++; $display("FAIL bypass%0d_data: got %h want %h", i, d, eds[i]); end
      n_checks++; if (f !== efs[i]) begin n_fail++; $display("FAIL bypass%0d_flags: got %b want %b", i, f, efs[i]); end
      n_checks++; if (st !== 0) begin n_fail++; $display("FAIL bypass%0d_start: got %0d cycles want 0", i, st); end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL bypass%0d_latency: got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d, fb; logic [2:0] f; logic [TAG_W-1:0] t; logic fm; int lat, st, un, rh; bit ok;
    fpu_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    run_op(OP_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd21, 0, d, f, t, lat, st, fb, fm, un, rh, ok);
    fpu_mode = 0;
    n_checks++; if (d !== CNAN) begin n_fail++; $display("FAIL timeout_data: got %h want 7FC00000", d); end
    n_checks++; if (f !== 3'b010) begin n_fail++; $display("FAIL timeout_flags: got %b want 010", f); end
    n_checks++; if (st !== 129) begin n_fail++; $display("FAIL timeout_start_cycles: got %0d want 129", st); end
    n_checks++; if (lat !== 131) begin n_fail++; $display("FAIL timeout_latency: got %0d want 131", lat); end
  endtask

  task automatic test_stall();
    logic [31:0] d, fb; logic [2:0] f; logic [TAG_W-1:0] t; logic fm; int lat, st, un, rh; bit ok;
    fpu_lat = 3;
    repeat (2) @(posedge clk);
    #1;
    run_op(OP_FMUL, 32'h4000_0000, 32'h4040_0000, 5'd19, 10, d, f, t, lat, st, fb, fm, un, rh, ok);
    n_checks++; if (un !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d changed cycles want 0", un); end
    n_checks++; if (rh !== 0) begin n_fail++; $display("FAIL stall_in_ready: got %0d high cycles want 0", rh); end
    n_checks++; if (d !== fpu_hash(32'h4000_0000, 32'h4040_0000, 1'b1)) begin n_fail++; $display("FAIL stall_data: got %h want %h", d, fpu_hash(32'h4000_0000, 32'h4040_0000, 1'b1)); end
    n_checks++; if (t !== 5'd19) begin n_fail++; $display("FAIL stall_tag: got %0d want 19", t); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got in_ready %b want 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    fpu_mode = 2;
    bus.in_valid = 1'b1; bus.in_op = OP_FMUL; bus.in_a = 32'h4000_0000; bus.in_b = 32'h4040_0000; bus.in_tag = 5'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if ({bus.fpu_start, bus.in_ready} !== 2'b10) begin n_fail++; $display("FAIL rstmid_waiting: got start/ready %b want 10", {bus.fpu_start, bus.in_ready}); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if ({bus.fpu_start, bus.fpu_mul, bus.res_valid} !== 3'b000) begin n_fail++; $display("FAIL rstmid_ctl: got %b want 000", {bus.fpu_start, bus.fpu_mul, bus.res_valid}); end
    n_checks++; if ({bus.fpu_a, bus.fpu_b, bus.res_data, bus.res_flags, bus.res_tag} !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h %h %h %b %h want 0", bus.fpu_a, bus.fpu_b, bus.res_data, bus.res_flags, bus.res_tag); end
    @(posedge clk); #1;
    rst = 1'b0;
    fpu_mode = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] d, fb, a, b, ed, eb; logic [2:0] f, ef; logic [TAG_W-1:0] t, tag; logic [1:0] op;
    logic fm; int lat, st, un, rh; bit ok, iss;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a = rand_operand();
      b = rand_operand();
      tag = 5'($urandom);
      fpu_lat = $urandom_range(1, 12);
      ref_model(op, a, b, iss, ed, ef, eb);
      run_op(op, a, b, tag, $urandom_range(0, 2), d, f, t, lat, st, fb, fm, un, rh, ok);
      n_checks++; if (d !== ed) begin n_fail++; $display("FAIL rnd%0d_data op=%b a=%h b=%h: got %h want %h", i, op, a, b, d, ed); end
      n_checks++; if (f !== ef) begin n_fail++; $display("FAIL rnd%0d_flags op=%b a=%h b=%h: got %b want %b", i, op, a, b, f, ef); end
      n_checks++; if (t !== tag) begin n_fail++; $display("FAIL rnd%0d_tag: got %0d want %0d", i, t, tag); end
      n_checks++; if (lat !== (iss ? 3 + fpu_lat : 3)) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, iss ? 3 + fpu_lat : 3); end
      n_checks++; if (st !== (iss ? fpu_lat + 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_start_cycles: got %0d want %0d", i, st, iss ? fpu_lat + 1 : 0); end
      if (iss) begin
        n_checks++; if ({fb, fm} !== {eb, op == OP_FMUL}) begin n_fail++; $display("FAIL rnd%0d_fpu_ops: got %h/%b want %h/%b", i, fb, fm, eb, op == OP_FMUL); end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_fadd();
    test_fsub_fmul();
    test_bypass();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
